operand_packer: RTL
===================

Name: operand_packer

Overview:
- Input stage directly upstream of the divider core, fed from the input pads.
- Collects 8-bit bytes strobed by `push_in` and assembles each group of 8 bytes plus the sign bit into one 65-bit operand word.
- Tags each word with its mode bit (`select`).
- Queues completed words in a small FIFO that the divider core drains with a valid/ready handshake.

Parameters:
- DATA_WIDTH, 65, operand word width: {sign, 64-bit payload}.
- BUFFER_DEPTH, 4, number of operand-FIFO entries; power of two.
- LOG_BUFFER_DEPTH, 3, pointer width = log2(BUFFER_DEPTH)+1; the extra bit distinguishes full from empty.
- BYTES_PER_WORD, 8, bytes per word = (DATA_WIDTH-1)/8.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- push_in  in  1  byte strobe; one byte is accepted per cycle while high.
- data_in_in  in  8  input byte.
- sign  in  1  operand sign, sampled together with the last byte of a word.
- select  in  1  mode bit (0 divr2, 1 fp32), sampled with the first byte of a word.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer takes the head word.
- out_data  out  DATA_WIDTH  head word: {sign, payload[63:0]}.
- out_select  out  1  mode bit of the head word.
- full  out  1  FIFO holds BUFFER_DEPTH entries.
- overflow  out  1  sticky; a byte was dropped.
- byte_cnt  out  3  number of bytes collected for the current word.

Behaviour:
- Reset (`rst`=1 at a clock edge):
  - FIFO pointers cleared; state = IDLE; shift register and byte_cnt cleared.
  - overflow=0; out_valid=0; out_data=0; out_select=0; full=0.
  - Reset overrides all simultaneous events and discards any partial word and all queued words.
- Byte ordering: little-endian. The first byte goes to payload[7:0]; the k-th byte (k=0..7) goes to payload[8k+7:8k].
- FSM states:
  - IDLE: byte_cnt=0. On push_in: store the byte, latch `select`, byte_cnt=1, go to COLLECT.
  - COLLECT: each push_in stores a byte and increments byte_cnt.
    - On the 8th byte at edge E, the word is {sign, data_in_in, shreg[55:0]}.
    - If the FIFO has space at E, the word is written at E, byte_cnt returns to 0, and the state goes to IDLE.
    - Otherwise the word is latched into a hold register and the state goes to STALL.
  - STALL: the hold register is written to the FIFO at the first edge where there is space, then the state goes to IDLE.
    - push_in during STALL: the byte is dropped and overflow is set.
    - Note: the payload assembles on the byte path, not the hold register, so STALL never corrupts the held word.
- FIFO space rule: space = !full || (out_valid && out_ready). A write and a pop in the same cycle are both performed, and the count is unchanged.
- Latency: a word written at edge E gives out_valid=1 in the cycle after E, provided the FIFO was empty. Last byte to out_valid is 1 cycle.
- Handshake:
  - out_data and out_select are stable while out_valid=1 and out_ready=0.
  - A pop happens at any edge with out_valid && out_ready.
  - out_ready while empty has no effect.
- Pointers: LOG_BUFFER_DEPTH bits each, wrapping modulo 2·BUFFER_DEPTH.
  - empty = (wr==rd).
  - full = (MSBs differ && lower bits equal).
- overflow clears only on rst.
- push_in stays high continuously: words pack back-to-back with no idle cycle.

Decomposition:
- Shared package holds:
  - BYTES_PER_WORD;
  - the FSM state encoding (IDLE=2'd0, COLLECT=2'd1, STALL=2'd2);
  - the FIFO entry width DATA_WIDTH+1.
- One sub-module, `operand_fifo`: a synchronous FIFO with wr_en/rd_en and full/empty, parameterised by width and depth. The packer FSM and hold register stay in operand_packer.

Test Plan:
- Reset, then push bytes 0x01..0x08 with sign=1, select=1 -> one cycle later out_valid=1, out_data=65'h1_0807060504030201, out_select=1, byte_cnt=0.
- Continuous push_in of 16 bytes 0x00..0x0F, out_ready=1 -> two words, 64'h0706050403020100 then 64'h0F0E0D0C0B0A0908, on consecutive pops; overflow=0.
- out_ready=0, push 5 words -> full=1 after 4 words, state STALL; a 41st byte sets overflow=1. Then one out_ready pulse -> the held 5th word enters at that same edge, full stays 1.
- FIFO full and in STALL with out_ready=1 -> simultaneous pop and write; count stays 4 and the entries drain in order 1..5.
- 3 bytes pushed, then rst=1 for one cycle -> byte_cnt=0, out_valid=0. The next 8 bytes 0xA0..0xA7 form 64'hA7A6A5A4A3A2A1A0 with no stale data.
- select=0 on byte 1 and toggled to 1 on bytes 2..8 -> out_select=0. The sign is taken from the 8th-byte cycle only.

Source files
------------

// File: rtl/operand_packer_pkg.sv
// Shared widths, FSM encoding and FIFO entry layout for the operand packer.
package operand_packer_pkg;

  localparam int unsigned DATA_WIDTH       = 65;
  localparam int unsigned PAYLOAD_WIDTH    = DATA_WIDTH - 1;
  localparam int unsigned BUFFER_DEPTH     = 4;
  localparam int unsigned LOG_BUFFER_DEPTH = 3;
  localparam int unsigned BYTES_PER_WORD   = PAYLOAD_WIDTH / 8;
  localparam int unsigned ENTRY_WIDTH      = DATA_WIDTH + 1;
  localparam int unsigned CNT_WIDTH        = 3;
  localparam int unsigned SHREG_WIDTH      = PAYLOAD_WIDTH - 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    STALL   = 2'd2
  } state_e;

  // FIFO entry: mode bit travels alongside the {sign, payload} operand word
  typedef struct packed {
    logic                     sel;
    logic                     sign;
    logic [PAYLOAD_WIDTH-1:0] payload;
  } entry_t;

endpackage

// File: rtl/operand_packer_if.sv
// Byte input and operand-word output bundle of the operand packer.
interface operand_packer_if;
  import operand_packer_pkg::*;

  logic                  push_in;
  logic [7:0]            data_in_in;
  logic                  sign;
  logic                  select;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_select;
  logic                  full;
  logic                  overflow;
  logic [CNT_WIDTH-1:0]  byte_cnt;

  modport master (
    output push_in, data_in_in, sign, select, out_ready,
    input  out_valid, out_data, out_select, full, overflow, byte_cnt
  );

  modport slave (
    input  push_in, data_in_in, sign, select, out_ready,
    output out_valid, out_data, out_select, full, overflow, byte_cnt
  );

endinterface

// File: rtl/operand_packer_fifo.sv
// Synchronous FIFO with wrap-bit pointers; head reads as zero while empty.
module operand_fifo #(
  parameter int unsigned WIDTH     = 66,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PTR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data_c,
  output logic             full_c,
  output logic             empty_c
);

  localparam int unsigned ADDR_WIDTH = PTR_WIDTH - 1;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic                 do_rd_c;
  logic                 do_wr_c;

  assign empty_c   = (wr_ptr == rd_ptr);
  assign full_c    = (wr_ptr[PTR_WIDTH-1] != rd_ptr[PTR_WIDTH-1]) &&
                     (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
  assign do_rd_c   = rd_en && !empty_c;
  assign do_wr_c   = wr_en && (!full_c || do_rd_c);
  assign rd_data_c = empty_c ? '0 : mem[rd_ptr[ADDR_WIDTH-1:0]];

  // Pointer update; a simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr_c) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_rd_c) rd_ptr <= rd_ptr + PTR_WIDTH'(1);
    end
  end

  // Storage array
  always_ff @(posedge clk) begin
    if (do_wr_c) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
  end

endmodule

// File: rtl/operand_packer.sv
// Assembles 8 pushed bytes plus sign into a 65-bit operand and queues it.
module operand_packer
  import operand_packer_pkg::*;
(
  input logic             clk,
  input logic             rst,
  operand_packer_if.slave bus
);

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [SHREG_WIDTH-1:0] shreg_q, shreg_d;
  logic                   sel_q, sel_d;
  entry_t                 hold_q, hold_d;
  logic                   ovf_q, ovf_d;
  entry_t                 word_c;
  entry_t                 wr_data_c;
  entry_t                 head_c;
  logic                   wr_en_c;
  logic                   full_c;
  logic                   empty_c;
  logic                   space_c;

  assign space_c = !full_c || (!empty_c && bus.out_ready);

  assign bus.out_valid  = !empty_c;
  assign bus.out_data   = {head_c.sign, head_c.payload};
  assign bus.out_select = head_c.sel;
  assign bus.full       = full_c;
  assign bus.overflow   = ovf_q;
  assign bus.byte_cnt   = cnt_q;

  operand_fifo #(
    .WIDTH     (ENTRY_WIDTH),
    .DEPTH     (BUFFER_DEPTH),
    .PTR_WIDTH (LOG_BUFFER_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en_c),
    .wr_data   (wr_data_c),
    .rd_en     (bus.out_ready),
    .rd_data_c (head_c),
    .full_c    (full_c),
    .empty_c   (empty_c)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      sel_q   <= 1'b0;
      hold_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      sel_q   <= sel_d;
      hold_q  <= hold_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next state: bytes shift in from the top so the first lands in [7:0]
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shreg_d        = shreg_q;
    sel_d          = sel_q;
    hold_d         = hold_q;
    ovf_d          = ovf_q;
    wr_en_c        = 1'b0;
    wr_data_c      = hold_q;
    word_c.sel     = sel_q;
    word_c.sign    = bus.sign;
    word_c.payload = {bus.data_in_in, shreg_q};

    case (state_q)
      IDLE: begin
        if (bus.push_in) begin
          shreg_d = {bus.data_in_in, shreg_q[SHREG_WIDTH-1:8]};
          sel_d   = bus.select;
          cnt_d   = CNT_WIDTH'(1);
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.push_in) begin
          if (cnt_q == CNT_WIDTH'(BYTES_PER_WORD - 1)) begin
            cnt_d = '0;
            if (space_c) begin
              wr_en_c   = 1'b1;
              wr_data_c = word_c;
              state_d   = IDLE;
            end else begin
              hold_d  = word_c;
              state_d = STALL;
            end
          end else begin
            shreg_d = {bus.data_in_in, shreg_q[SHREG_WIDTH-1:8]};
            cnt_d   = cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      STALL: begin
        if (bus.push_in) ovf_d = 1'b1;
        if (space_c) begin
          wr_en_c   = 1'b1;
          wr_data_c = hold_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
